servile_sram_wb_arbiter: RTL and testbench
==========================================

// Module: servile_sram_wb_arbiter
// PURPOSE
//  Shares one byte-wide SRAM between two 32-bit Wishbone-classic requesters (port 0, port 1).
//  Arbitrates round-robin and serialises each word access into four byte accesses.
//  Yields the SRAM to the register file whenever i_hold is high.
//  Sits between the requesters and the RF/memory SRAM mux; the SRAM itself is external.
// PARAMETERS
//  depth  256            SRAM size in bytes (power of two, >=16)
//  aw     $clog2(depth)  SRAM byte-address width (derived, do not override)
// PORTS
//  i_clk         in   1      clock, all logic on rising edge
//  i_rst_n       in   1      reset, asynchronous, active-low
//  i_hold        in   1      RF owns SRAM this cycle; arbiter must not strobe
//  i_wb0_adr     in   aw-2   port 0 word address
//  i_wb0_dat     in   32     port 0 write data
//  i_wb0_sel     in   4      port 0 byte enables
//  i_wb0_we      in   1      port 0 write
//  i_wb0_stb     in   1      port 0 request
//  o_wb0_ack     out  1      port 0 single-cycle acknowledge
//  i_wb1_*       in   -      port 1 request, same as port 0 (adr, dat, sel, we, stb)
//  o_wb1_ack     out  1      port 1 single-cycle acknowledge
//  o_wb_rdt      out  32     read data, shared by both ports; valid only while that port's ack is high
//  o_sram_addr   out  aw     SRAM byte address
//  o_sram_wdata  out  8      SRAM write data
//  o_sram_wen    out  1      SRAM write strobe
//  o_sram_ren    out  1      SRAM read strobe; data is on i_sram_rdata next cycle
//  i_sram_rdata  in   8      SRAM read data
//  o_busy        out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, bsel=0, last_grant=1, acks=0, strobes=0, o_wb_rdt=0.
//  FSM states: IDLE -> XFER -> DONE -> IDLE.
//  IDLE:
//   - Any stb: grant port = (both requesting) ? !last_grant : the requesting port.
//   - Latch adr/dat/sel/we of the granted port, bsel=0, go to XFER.
//   - No SRAM strobes in IDLE.
//  XFER, i_hold=0 (one byte per cycle):
//   - o_sram_addr = {adr_q, bsel}; o_sram_wdata = dat_q[8*bsel+:8].
//   - Write: o_sram_wen = sel_q[bsel]. Read: o_sram_ren = 1.
//   - bsel += 1; after bsel=3 is issued go to DONE.
//  XFER, i_hold=1: wen=ren=0, bsel and state frozen. No timeout.
//  Read capture: a registered issue flag plus byte index stores i_sram_rdata into rdt[8*idx+:8]
//   one cycle after each ren, independent of i_hold.
//  DONE:
//   - Granted port's ack=1 for exactly this one cycle; o_wb_rdt holds the complete word.
//   - last_grant = granted port; next state IDLE.
//   - i_hold is ignored (no SRAM use).
//  Latency with no hold: stb seen in IDLE at cycle 0, bytes in cycles 1-4, ack in cycle 5.
//   Each held XFER cycle adds 1.
//  Ack is state-decoded: never asserted in IDLE, so no double ack.
//   A port holding stb high sees ack once per 6-cycle transaction.
//  Write with sel bits 0: the byte slot still costs one cycle with wen=0. sel=0000 still acks.
//  Address wrap: the byte address is simply {adr_q, bsel}; no carry into adr_q.
//  Dropping stb mid-transaction is illegal; the transaction still completes and acks.
//  Fairness: under continuous requests from both ports, grants strictly alternate.
//  Reset mid-transaction: immediate return to IDLE, no ack, partial SRAM writes persist.
//  o_sram_addr/o_sram_wdata are don't-care when both strobes are 0.
// TESTING
//  1. P0 write adr=5, dat=0xA1B2C3D4, sel=1111 -> wen on addr 20,21,22,23 with D4,C3,B2,A1
//     in cycles 1-4; ack0 in cycle 5.
//  2. P1 read adr=5 after test 1 -> ren on addr 20..23; ack1 in cycle 5 with o_wb_rdt=0xA1B2C3D4.
//  3. Both stb in the same cycle after reset -> P0 granted first, P1 acked 6 cycles later;
//     held requests alternate 0,1,0,1.
//  4. P0 write sel=0101 -> wen=1 only at bytes 0 and 2; ack still in cycle 5.
//  5. Read with i_hold=1 for 3 cycles at bsel=2 -> no strobes while held; ack in cycle 8;
//     data correct.
//  6. i_rst_n pulled low during XFER -> all outputs 0 asynchronously, no ack;
//     next request completes normally in 6 cycles.

Source files
------------

// File: rtl/servile_sram_wb_arbiter.sv
// Round-robin arbiter sharing one byte-wide SRAM between two 32-bit Wishbone-classic ports.
// Each word access is split into four byte accesses; the register file may pre-empt via i_hold.
module servile_sram_wb_arbiter #(
   parameter  int depth = 256,
   localparam int aw    = $clog2(depth)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_hold,
   input  logic [aw-3:0] i_wb0_adr,
   input  logic [31:0]   i_wb0_dat,
   input  logic [3:0]    i_wb0_sel,
   input  logic          i_wb0_we,
   input  logic          i_wb0_stb,
   output logic          o_wb0_ack,
   input  logic [aw-3:0] i_wb1_adr,
   input  logic [31:0]   i_wb1_dat,
   input  logic [3:0]    i_wb1_sel,
   input  logic          i_wb1_we,
   input  logic          i_wb1_stb,
   output logic          o_wb1_ack,
   output logic [31:0]   o_wb_rdt,
   output logic [aw-1:0] o_sram_addr,
   output logic [7:0]    o_sram_wdata,
   output logic          o_sram_wen,
   output logic          o_sram_ren,
   input  logic [7:0]    i_sram_rdata,
   output logic          o_busy
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic          grant;
   logic          last_grant;
   logic          pick;
   logic          any_stb;
   logic [aw-3:0] adr_q;
   logic [31:0]   dat_q;
   logic [3:0]    sel_q;
   logic          we_q;
   logic [1:0]    bsel;
   logic          rd_issue;
   logic [1:0]    rd_idx;
   logic [31:0]   rdt;
   logic [31:0]   rdt_next;

   assign any_stb = i_wb0_stb | i_wb1_stb;
   assign pick    = (i_wb0_stb & i_wb1_stb) ? ~last_grant : i_wb1_stb;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_sram_wen = 1'b0;
      o_sram_ren = 1'b0;
      o_wb0_ack  = 1'b0;
      o_wb1_ack  = 1'b0;
      case (state)
         IDLE: begin
            if (any_stb) state_next = XFER;
         end
         XFER: begin
            if (!i_hold) begin
               if (we_q) o_sram_wen = sel_q[bsel];
               else      o_sram_ren = 1'b1;
               if (bsel == 2'd3) state_next = DONE;
            end
         end
         DONE: begin
            o_wb0_ack  = ~grant;
            o_wb1_ack  = grant;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The last read byte arrives during DONE, so it is merged combinationally into the output word.
   always_comb begin
      rdt_next = rdt;
      if (rd_issue) rdt_next[{rd_idx, 3'b000} +: 8] = i_sram_rdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         bsel       <= 2'd0;
         rd_issue   <= 1'b0;
         rd_idx     <= 2'd0;
         rdt        <= '0;
      end else begin
         rd_issue <= o_sram_ren;
         rd_idx   <= bsel;
         rdt      <= rdt_next;
         case (state)
            IDLE: begin
               if (any_stb) begin
                  grant <= pick;
                  adr_q <= pick ? i_wb1_adr : i_wb0_adr;
                  dat_q <= pick ? i_wb1_dat : i_wb0_dat;
                  sel_q <= pick ? i_wb1_sel : i_wb0_sel;
                  we_q  <= pick ? i_wb1_we  : i_wb0_we;
                  bsel  <= 2'd0;
               end
            end
            XFER: begin
               if (!i_hold) bsel <= bsel + 2'd1;
            end
            DONE: begin
               last_grant <= grant;
            end
            default: ;
         endcase
      end
   end

   assign o_sram_addr  = {adr_q, bsel};
   assign o_sram_wdata = dat_q[{bsel, 3'b000} +: 8];
   assign o_wb_rdt     = rdt_next;
   assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_servile_sram_wb_arbiter.sv
// Directed bench for servile_sram_wb_arbiter: vector table of word transactions against a
// behavioural byte SRAM, plus hand-written arbitration and mid-transaction reset sequences.
module tb_servile_sram_wb_arbiter;

   typedef struct {
      logic        port;
      logic        we;
      logic [5:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          hold_bsel;
      int          hold_len;
      logic [31:0] exp_rdt;
      int          ack_cycle;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic [5:0]  wb0_adr = '0, wb1_adr = '0;
   logic [31:0] wb0_dat = '0, wb1_dat = '0;
   logic [3:0]  wb0_sel = '0, wb1_sel = '0;
   logic        wb0_we = 1'b0, wb1_we = 1'b0;
   logic        wb0_stb = 1'b0, wb1_stb = 1'b0;
   logic        wb0_ack, wb1_ack;
   logic [31:0] wb_rdt;
   logic [7:0]  sram_addr;
   logic [7:0]  sram_wdata;
   logic        sram_wen, sram_ren;
   logic [7:0]  sram_rdata;
   logic        busy;

   logic [7:0]  mem [256];
   int          n_checks = 0;
   int          n_fails = 0;
   vec_t        vecs [8];

   servile_sram_wb_arbiter #(.depth(256)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_hold(hold),
      .i_wb0_adr(wb0_adr),
      .i_wb0_dat(wb0_dat),
      .i_wb0_sel(wb0_sel),
      .i_wb0_we(wb0_we),
      .i_wb0_stb(wb0_stb),
      .o_wb0_ack(wb0_ack),
      .i_wb1_adr(wb1_adr),
      .i_wb1_dat(wb1_dat),
      .i_wb1_sel(wb1_sel),
      .i_wb1_we(wb1_we),
      .i_wb1_stb(wb1_stb),
      .o_wb1_ack(wb1_ack),
      .o_wb_rdt(wb_rdt),
      .o_sram_addr(sram_addr),
      .o_sram_wdata(sram_wdata),
      .o_sram_wen(sram_wen),
      .o_sram_ren(sram_ren),
      .i_sram_rdata(sram_rdata),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Byte SRAM with one-cycle read latency; preloaded with addr ^ 0x5A.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      sram_rdata = 8'h00;
      forever begin
         @(posedge clk);
         if (sram_wen) mem[sram_addr] <= sram_wdata;
         if (sram_ren) sram_rdata <= mem[sram_addr];
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_acks"}, 32'({wb1_ack, wb0_ack}), 32'd0);
      checkOutput({tag, "_strobes"}, 32'({sram_wen, sram_ren}), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_addr"}, 32'(sram_addr), 32'd0);
      checkOutput({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
      checkOutput({tag, "_rdt"}, wb_rdt, 32'd0);
   endtask

   // Entered just after a rising edge; returns just after the edge following the ack cycle.
   task automatic applyStimulus(input vec_t v);
      int   b;
      int   held;
      logic hold_now;
      logic exp_wen;
      if (v.port) begin
         wb1_adr = v.adr; wb1_dat = v.dat; wb1_sel = v.sel; wb1_we = v.we; wb1_stb = 1'b1;
      end else begin
         wb0_adr = v.adr; wb0_dat = v.dat; wb0_sel = v.sel; wb0_we = v.we; wb0_stb = 1'b1;
      end
      hold = 1'b0;
      @(negedge clk);
      checkOutput("idle_acks", 32'({wb1_ack, wb0_ack}), 32'd0);
      checkOutput("idle_strobes", 32'({sram_wen, sram_ren}), 32'd0);
      b = 0;
      held = 0;
      for (int c = 1; c <= v.ack_cycle; c++) begin
         @(posedge clk); #1;
         hold_now = (c < v.ack_cycle) && (b == v.hold_bsel) && (held < v.hold_len);
         hold = hold_now;
         @(negedge clk);
         if (c < v.ack_cycle) begin
            checkOutput("early_acks", 32'({wb1_ack, wb0_ack}), 32'd0);
            checkOutput("busy", 32'(busy), 32'd1);
            if (hold_now) begin
               checkOutput("held_strobes", 32'({sram_wen, sram_ren}), 32'd0);
               held++;
            end else begin
               exp_wen = v.we & v.sel[b];
               checkOutput("strobes", 32'({sram_wen, sram_ren}), 32'({exp_wen, ~v.we}));
               checkOutput("addr", 32'(sram_addr), 32'({v.adr, b[1:0]}));
               if (exp_wen) checkOutput("wdata", 32'(sram_wdata), 32'(v.dat[8*b +: 8]));
               b++;
            end
         end else begin
            checkOutput("ack", 32'({wb1_ack, wb0_ack}), v.port ? 32'd2 : 32'd1);
            checkOutput("done_strobes", 32'({sram_wen, sram_ren}), 32'd0);
            if (!v.we) checkOutput("rdata", wb_rdt, v.exp_rdt);
         end
      end
      @(posedge clk); #1;
      wb0_stb = 1'b0;
      wb1_stb = 1'b0;
      hold = 1'b0;
   endtask

   initial begin
      //           port  we    adr    dat            sel   hbsel hlen exp_rdt        ack
      vecs[0] = '{1'b0, 1'b1, 6'd5,  32'hA1B2C3D4, 4'hF, -1,   0,   32'h0,         5};
      vecs[1] = '{1'b1, 1'b0, 6'd5,  32'h0,        4'h0, -1,   0,   32'hA1B2C3D4,  5};
      vecs[2] = '{1'b0, 1'b1, 6'd9,  32'h11223344, 4'h5, -1,   0,   32'h0,         5};
      vecs[3] = '{1'b1, 1'b0, 6'd9,  32'h0,        4'h0, 2,    3,   32'h7D227F44,  8};
      vecs[4] = '{1'b0, 1'b0, 6'd63, 32'h0,        4'h0, -1,   0,   32'hA5A4A7A6,  5};
      vecs[5] = '{1'b1, 1'b1, 6'd63, 32'hDEADBEEF, 4'h0, -1,   0,   32'h0,         5};
      vecs[6] = '{1'b0, 1'b0, 6'd63, 32'h0,        4'h0, -1,   0,   32'hA5A4A7A6,  5};
      vecs[7] = '{1'b1, 1'b0, 6'd0,  32'h0,        4'h0, 0,    1,   32'h59585B5A,  6};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Both ports requesting continuously from a fresh reset: port 0 first, then strict alternation.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      wb0_adr = 6'd2; wb0_dat = 32'h01020304; wb0_sel = 4'hF; wb0_we = 1'b1; wb0_stb = 1'b1;
      wb1_adr = 6'd2; wb1_dat = 32'h0;        wb1_sel = 4'h0; wb1_we = 1'b0; wb1_stb = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c % 6 == 5)
            checkOutput("rr_acks", 32'({wb1_ack, wb0_ack}), ((c / 6) % 2 == 1) ? 32'd2 : 32'd1);
         else
            checkOutput("rr_acks", 32'({wb1_ack, wb0_ack}), 32'd0);
         if (c == 11 || c == 23) checkOutput("rr_rdata", wb_rdt, 32'h01020304);
         @(posedge clk); #1;
      end
      wb0_stb = 1'b0;
      wb1_stb = 1'b0;

      // Reset in the middle of a write: outputs clear at once, first two bytes stay written.
      wb0_adr = 6'd7; wb0_dat = 32'hCAFEF00D; wb0_sel = 4'hF; wb0_we = 1'b1; wb0_stb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      wb0_stb = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("post_reset_acks", 32'({wb1_ack, wb0_ack}), 32'd0);
         checkOutput("post_reset_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      applyStimulus('{1'b0, 1'b0, 6'd7, 32'h0, 4'h0, -1, 0, 32'h4544F00D, 5});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
